// File: rtl/skip_adder_seq_pkg.sv
// +----------------------------------------------------------------------+
// | skip_adder_seq_pkg : shared state encoding and sizing helpers         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package skip_adder_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  // Skip counter must hold the value NBLK itself, hence the +1.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skip_adder_seq_block.sv
// +----------------------------------------------------------------------+
// | skip_block : BLOCK-bit ripple of skip full-adder cells with skip mux  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module skip_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             prop_o,
  output logic             cmsb_o
);

  logic [BLOCK:0]   c;
  logic [BLOCK-1:0] p;

  assign c[0] = cin_i;

  for (genvar i = 0; i < BLOCK; i++) begin : g_cell
    assign p[i]     = a_i[i] ^ b_i[i];
    assign sum_o[i] = p[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (p[i] & c[i]);
  end

  // When every bit propagates, the ripple result equals cin_i anyway;
  // the mux just shortens the path.
  assign prop_o = &p;
  assign cout_o = prop_o ? cin_i : c[BLOCK];
  assign cmsb_o = c[BLOCK-1];

endmodule

`default_nettype wire

// File: rtl/skip_adder_seq.sv
// +----------------------------------------------------------------------+
// | skip_adder_seq : multi-cycle carry-skip adder, one group per clock    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module skip_adder_seq
  import skip_adder_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  localparam int NBLK = nblk(WIDTH, BLOCK),
  localparam int CW   = cnt_w(NBLK),
  localparam int IW   = idx_w(NBLK)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carryin_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carryout_o,
  output logic             overflow_o,
  output logic [CW-1:0]    skipcount_o
);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d;
  logic             carry_q;
  logic [CW-1:0]    skip_q, skip_d;
  logic             done_q, carryout_q, overflow_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    skipcount_q;

  logic [BLOCK-1:0] grp_a, grp_b, grp_sum;
  logic             grp_cout, grp_prop, grp_cmsb;
  logic             last_grp;

  always_comb begin
    grp_a    = a_q[idx_q*BLOCK +: BLOCK];
    grp_b    = b_q[idx_q*BLOCK +: BLOCK];
    acc_d    = acc_q;
    acc_d[idx_q*BLOCK +: BLOCK] = grp_sum;
    skip_d   = skip_q + CW'(grp_prop);
    last_grp = (idx_q == IW'(NBLK - 1));
  end

  skip_block #(.BLOCK(BLOCK)) u_blk (
    .a_i    (grp_a),
    .b_i    (grp_b),
    .cin_i  (carry_q),
    .sum_o  (grp_sum),
    .cout_o (grp_cout),
    .prop_o (grp_prop),
    .cmsb_o (grp_cmsb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      skip_q      <= '0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      skipcount_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= carryin_i;
            acc_q   <= '0;
            skip_q  <= '0;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          carry_q <= grp_cout;
          skip_q  <= skip_d;
          idx_q   <= idx_q + IW'(1);
          // Final group: publish results on the same edge that enters DONE.
          if (last_grp) begin
            sum_q       <= acc_d;
            carryout_q  <= grp_cout;
            overflow_q  <= grp_cmsb ^ grp_cout;
            skipcount_q <= skip_d;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == S_IDLE);
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carryout_o  = carryout_q;
  assign overflow_o  = overflow_q;
  assign skipcount_o = skipcount_q;

endmodule

`default_nettype wire

// File: tb/tb_skip_adder_seq.sv
// +----------------------------------------------------------------------+
// | tb_skip_adder_seq : directed vectors with queue-based scoreboard      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_skip_adder_seq;

  localparam int PER = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [15:0] a_i, b_i;
  logic        carryin_i;
  logic        ready_o, done_o, carryout_o, overflow_o;
  logic [15:0] sum_o;
  logic [2:0]  skipcount_o;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    logic [2:0]  sk;
    time         t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;
  time  t_a, t_b;

  skip_adder_seq #(.WIDTH(16), .BLOCK(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .carryin_i   (carryin_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .sum_o       (sum_o),
    .carryout_o  (carryout_o),
    .overflow_o  (overflow_o),
    .skipcount_o (skipcount_o)
  );

  always #(PER/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (done_o) begin
        chk("done_not_consecutive", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation");
        end else begin
          mon_e = sb.pop_front();
          chk("sum",       32'(sum_o),       32'(mon_e.sum));
          chk("carryout",  32'(carryout_o),  32'(mon_e.co));
          chk("overflow",  32'(overflow_o),  32'(mon_e.ov));
          chk("skipcount", 32'(skipcount_o), 32'(mon_e.sk));
          chk("latency",   32'(($time - mon_e.t0) / PER), 32'd4);
        end
      end
      prev_done = done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic eco, input logic eov,
                       input logic [2:0] esk, input bit keep, output time tacc);
    int k;
    exp_t e;
    a_i       = a;
    b_i       = b;
    carryin_i = cin;
    start_i   = 1'b1;
    k = 0;
    while (!ready_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) chk("ready_timeout", 32'(ready_o), 32'd1);
    @(posedge clk);
    tacc  = $time;
    e.sum = es;
    e.co  = eco;
    e.ov  = eov;
    e.sk  = esk;
    e.t0  = $time;
    sb.push_back(e);
    @(negedge clk);
    if (!keep) start_i = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"},     32'(ready_o),     32'd1);
    chk({tag, "_done"},      32'(done_o),      32'd0);
    chk({tag, "_sum"},       32'(sum_o),       32'd0);
    chk({tag, "_carryout"},  32'(carryout_o),  32'd0);
    chk({tag, "_overflow"},  32'(overflow_o),  32'd0);
    chk({tag, "_skipcount"}, 32'(skipcount_o), 32'd0);
  endtask

  initial begin
    #(PER * 5000);
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start_i   = 1'b0;
    a_i       = '0;
    b_i       = '0;
    carryin_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_cleared("reset");

    issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 3'd0, 1'b0, t_a);
    issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 1'b0, t_a);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3'd2, 1'b0, t_a);
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0, t_a);
    issue(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0, 3'd4, 1'b0, t_a);
    issue(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 1'b0, t_a);

    // start held high; operands disturbed mid-RUN must not affect op 1
    issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 3'd1, 1'b1, t_a);
    a_i       = 16'hFFFF;
    b_i       = 16'hFFFF;
    carryin_i = 1'b1;
    repeat (2) @(negedge clk);
    issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 3'd2, 1'b0, t_b);
    chk("issue_interval", 32'((t_b - t_a) / PER), 32'd6);

    // Abort an operation with an asynchronous reset in its second RUN cycle
    repeat (8) @(negedge clk);
    issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 3'd0, 1'b0, t_a);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_cleared("async_reset");
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", 32'(sb.size()), 32'd0);

    issue(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 3'd0, 1'b0, t_a);
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
